// File: rtl/wb_risc_host_port.sv
// Wishbone responder giving the management core CTRL/STATUS/SCRATCH registers and an IMEM window.
// Acks at k+1 (registers, IMEM writes, blocked/unmapped) or k+3 (IMEM reads); never stalls, cyc drop aborts a read.
module wb_risc_host_port #(
  parameter logic [15:0] BASE_HI = 16'h3000,
  parameter int          IMEM_AW = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic [31:0]        wbs_dat_o,
  output logic               wbs_ack_o,
  output logic               imem_en_o,
  output logic               imem_we_o,
  output logic [1:0]         imem_wmask_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [15:0]        imem_wdata_o,
  input  logic [15:0]        imem_rdata_i,
  output logic               core_run_o,
  output logic               core_rst_o,
  input  logic [15:0]        core_pc_i,
  input  logic               core_halted_i
);

  localparam logic [15:0] IMEM_BASE = 16'h1000;

  typedef enum logic [1:0] {IDLE, RD1, RD2, ACK} state_t;

  state_t      state;
  logic        run;
  logic        core_rst;
  logic        acc_err;
  logic [31:0] scratch;

  logic [15:0] off;
  logic        req;
  logic        is_ctrl;
  logic        is_status;
  logic        is_scratch;
  logic        is_imem;
  logic        err_set;
  logic        err_clr;
  logic [31:0] reg_rdata;

  assign core_run_o = run;
  assign core_rst_o = core_rst;

  always_comb begin
    off        = wbs_adr_i[15:0];
    req        = (state == IDLE) && wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:16] == BASE_HI);
    is_ctrl    = (off == 16'h0000);
    is_status  = (off == 16'h0004);
    is_scratch = (off == 16'h0008);
    // The window is aligned to its own size, so a prefix compare on the offset suffices.
    is_imem    = (off[15:IMEM_AW+2] == IMEM_BASE[15:IMEM_AW+2]);
    err_set    = req && is_imem && run;
    err_clr    = req && wbs_we_i && is_status && wbs_sel_i[2] && wbs_dat_i[17];
    reg_rdata  = 32'h0;
    if (is_ctrl)
      reg_rdata = {30'h0, core_rst, run};
    else if (is_status)
      reg_rdata = {14'h0, acc_err, core_halted_i, core_pc_i};
    else if (is_scratch)
      reg_rdata = scratch;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state        <= IDLE;
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= 32'h0;
      imem_en_o    <= 1'b0;
      imem_we_o    <= 1'b0;
      imem_wmask_o <= 2'b00;
      imem_addr_o  <= '0;
      imem_wdata_o <= 16'h0;
      run          <= 1'b0;
      core_rst     <= 1'b1;
      scratch      <= 32'h0;
      acc_err      <= 1'b0;
    end else begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
      imem_en_o <= 1'b0;
      imem_we_o <= 1'b0;

      // A new error beats a simultaneous host clear.
      if (err_set)
        acc_err <= 1'b1;
      else if (err_clr)
        acc_err <= 1'b0;

      unique case (state)
        IDLE: begin
          if (req) begin
            state     <= ACK;
            wbs_ack_o <= 1'b1;
            if (is_imem) begin
              if (!run) begin
                imem_en_o    <= 1'b1;
                imem_we_o    <= wbs_we_i;
                imem_addr_o  <= wbs_adr_i[IMEM_AW+1:2];
                imem_wdata_o <= wbs_dat_i[15:0];
                imem_wmask_o <= wbs_sel_i[1:0];
                if (!wbs_we_i) begin
                  state     <= RD1;
                  wbs_ack_o <= 1'b0;
                end
              end
            end else if (wbs_we_i) begin
              if (is_ctrl && wbs_sel_i[0])
                {core_rst, run} <= wbs_dat_i[1:0];
              if (is_scratch)
                for (int b = 0; b < 4; b++)
                  if (wbs_sel_i[b])
                    scratch[8*b +: 8] <= wbs_dat_i[8*b +: 8];
            end else begin
              wbs_dat_o <= reg_rdata;
            end
          end
        end
        RD1: state <= wbs_cyc_i ? RD2 : IDLE;
        RD2: begin
          if (wbs_cyc_i) begin
            wbs_dat_o <= {16'h0, imem_rdata_i};
            wbs_ack_o <= 1'b1;
            state     <= ACK;
          end else begin
            state <= IDLE;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
